mux158_arbiter: RTL and testbench

- Round-robin arbiter that shares one SN74XX158 quad 2-to-1 selector between two 4-bit requesters, A and B.
- Drives the selector's sel and strobe inputs.
- Gives each requester a bounded burst.
- Inserts one break-before-make guard cycle (strobe inactive) on every source switch, so the selector output never shows a mixed A/B transition.

---
 rtl/mux158_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mux158_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux158_arbiter.sv
// Round-robin arbiter sharing one SN74XX158 quad 2-to-1 selector between requesters A and B,
// with bounded bursts and a strobe-off guard cycle on every switch. Optional MUX158_ARB_LOCK_EN adds burst locks.
module mux158_arbiter #(
  parameter int unsigned HOLD  = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
`ifdef MUX158_ARB_LOCK_EN
  input  logic lock_a,
  input  logic lock_b,
`endif
  output logic gnt_a,
  output logic gnt_b,
  output logic mux_sel,
  output logic mux_str,
  output logic busy
);

  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_A = 2'd1,
    S_GNT_B = 2'd2,
    S_GUARD = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_b_q, last_b_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             sel_q, sel_d;
  logic             str_q, str_d;
  logic             busy_q, busy_d;

  logic owner_b_c;
  logic own_req_c;
  logic oth_req_c;
  logic at_hold_c;
  logic lock_own_c;

  // Requests seen from the current owner's point of view
  always_comb begin
    owner_b_c = (state_q == S_GNT_B);
    own_req_c = owner_b_c ? req_b : req_a;
    oth_req_c = owner_b_c ? req_a : req_b;
    at_hold_c = (cnt_q == HOLD_C);
  end

`ifdef MUX158_ARB_LOCK_EN
  // Only the owner's lock suspends burst expiry
  always_comb begin
    lock_own_c = 1'b0;
    if (state_q == S_GNT_A) lock_own_c = lock_a;
    if (state_q == S_GNT_B) lock_own_c = lock_b;
  end
`else
  assign lock_own_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, burst counter and fairness bookkeeping
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          cnt_d   = ONE_C;
          state_d = (req_a && (!req_b || last_b_q)) ? S_GNT_A : S_GNT_B;
        end
      end
      S_GNT_A, S_GNT_B: begin
        if (!own_req_c) begin
          last_b_d = owner_b_c;
          cnt_d    = ZERO_C;
          state_d  = oth_req_c ? S_GUARD : S_IDLE;
        end else if (at_hold_c && !lock_own_c) begin
          if (oth_req_c) begin
            last_b_d = owner_b_c;
            cnt_d    = ZERO_C;
            state_d  = S_GUARD;
          end else begin
            cnt_d = ONE_C;
          end
        end else if (!at_hold_c) begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_GUARD: begin
        // sel_q already points at the pending requester here
        if (sel_q ? req_b : req_a) begin
          cnt_d   = ONE_C;
          state_d = sel_q ? S_GNT_B : S_GNT_A;
        end else if (sel_q ? req_a : req_b) begin
          cnt_d   = ONE_C;
          state_d = sel_q ? S_GNT_A : S_GNT_B;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the state being entered, so outputs flop alongside the state
  always_comb begin
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    sel_d   = sel_q;
    str_d   = 1'b1;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_GNT_A: begin
        gnt_a_d = 1'b1;
        sel_d   = 1'b0;
        str_d   = 1'b0;
      end
      S_GNT_B: begin
        gnt_b_d = 1'b1;
        sel_d   = 1'b1;
        str_d   = 1'b0;
      end
      S_GUARD: sel_d = (state_q == S_GNT_A);
      default: sel_d = sel_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= ZERO_C;
      last_b_q <= 1'b1;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      sel_q    <= 1'b0;
      str_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      sel_q    <= sel_d;
      str_q    <= str_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt_a   = gnt_a_q;
  assign gnt_b   = gnt_b_q;
  assign mux_sel = sel_q;
  assign mux_str = str_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mux158_arbiter.sv
// Self-checking bench for mux158_arbiter: directed scenarios plus random traffic against a burst-level model.
module tb_mux158_arbiter;
  localparam int unsigned HOLD  = 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [3:0] IN_A = 4'ha;
  localparam logic [3:0] IN_B = 4'hf;

  logic clk = 1'b0;
  logic rst, req_a, req_b;
`ifdef MUX158_ARB_LOCK_EN
  logic lock_a, lock_b;
`endif
  logic gnt_a, gnt_b, mux_sel, mux_str, busy;

  int checks = 0;
  int failures = 0;

  // Model: owner -1 none / 0 A / 1 B, run = granted cycles in the current burst
  int m_owner, m_pend, m_run;
  bit m_guard, m_lastb, m_sel;

  always #5 clk = ~clk;

  mux158_arbiter #(.HOLD(HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
`ifdef MUX158_ARB_LOCK_EN
    .lock_a(lock_a), .lock_b(lock_b),
`endif
    .gnt_a(gnt_a), .gnt_b(gnt_b), .mux_sel(mux_sel), .mux_str(mux_str), .busy(busy)
  );

  function automatic logic [3:0] out158(input logic s, input logic str);
    return str ? 4'hf : ~(s ? IN_B : IN_A);
  endfunction

  function automatic logic [4:0] exp_vec();
    logic ga, gb;
    ga = (m_owner == 0);
    gb = (m_owner == 1);
    return {ga, gb, m_sel, !(ga || gb), (m_owner >= 0) || m_guard};
  endfunction

  task automatic model_step();
    bit r[2];
    bit lk[2];
    int x, o;
    r[0] = req_a; r[1] = req_b;
    lk[0] = 1'b0; lk[1] = 1'b0;
`ifdef MUX158_ARB_LOCK_EN
    lk[0] = lock_a; lk[1] = lock_b;
`endif
    if (rst) begin
      m_owner = -1; m_guard = 0; m_sel = 0; m_lastb = 1; m_run = 0; m_pend = 0;
    end else if (m_guard) begin
      m_guard = 0; x = m_pend; o = 1 - x;
      if (r[x]) begin m_owner = x; m_run = 1; m_sel = x[0]; end
      else if (r[o]) begin m_owner = o; m_run = 1; m_sel = o[0]; end
      else m_owner = -1;
    end else if (m_owner < 0) begin
      if (r[0] || r[1]) begin
        x = (r[0] && r[1]) ? (m_lastb ? 0 : 1) : (r[0] ? 0 : 1);
        m_owner = x; m_run = 1; m_sel = x[0];
      end
    end else begin
      x = m_owner; o = 1 - x;
      if (!r[x] || (m_run >= int'(HOLD) && !lk[x] && r[o])) begin
        m_lastb = (x == 1); m_owner = -1;
        if (r[o]) begin m_guard = 1; m_pend = o; m_sel = o[0]; end
      end else if (m_run >= int'(HOLD) && !lk[x]) m_run = 1;
      else m_run++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
`ifdef MUX158_ARB_LOCK_EN
    lock_a = 1'b0; lock_b = 1'b0;
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
`ifdef MUX158_ARB_LOCK_EN
    lock_a = 1'b0; lock_b = 1'b0;
`endif
    tick(); tick();
    checks++;
    if ({gnt_a, gnt_b, mux_sel, mux_str, busy} !== 5'b00010) begin
      failures++; $display("FAIL reset_state got=%b want=00010", {gnt_a, gnt_b, mux_sel, mux_str, busy});
    end
    checks++;
    if (out158(mux_sel, mux_str) !== 4'hf) begin
      failures++; $display("FAIL reset_out got=%h want=f", out158(mux_sel, mux_str));
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    req_a = 1'b1;
    tick();
    checks++;
    if ({gnt_a, gnt_b, mux_sel, mux_str, busy} !== exp_vec() || gnt_a !== 1'b1) begin
      failures++; $display("FAIL single_grant got=%b want=%b", {gnt_a, gnt_b, mux_sel, mux_str, busy}, exp_vec());
    end
    checks++;
    if (out158(mux_sel, mux_str) !== 4'b0101) begin
      failures++; $display("FAIL single_out got=%b want=0101", out158(mux_sel, mux_str));
    end
    req_a = 1'b0;
    tick();
    checks++;
    if ({gnt_a, gnt_b, mux_sel, mux_str, busy} !== exp_vec()) begin
      failures++; $display("FAIL single_release got=%b want=%b", {gnt_a, gnt_b, mux_sel, mux_str, busy}, exp_vec());
    end
  endtask

  task automatic test_tie();
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({gnt_a, gnt_b, mux_sel, mux_str, busy} !== exp_vec()) begin
        failures++; $display("FAIL tie_cycle%0d got=%b want=%b", i, {gnt_a, gnt_b, mux_sel, mux_str, busy}, exp_vec());
      end
      if (i == 0 || i == 18) begin
        checks++;
        if (gnt_a !== 1'b1) begin failures++; $display("FAIL tie_a_first cyc=%0d got=%b want=1", i, gnt_a); end
      end
      if (i == 8) begin
        checks++;
        if ({mux_str, mux_sel, out158(mux_sel, mux_str)} !== {2'b11, 4'hf}) begin
          failures++; $display("FAIL tie_guard got=%b want=111111", {mux_str, mux_sel, out158(mux_sel, mux_str)});
        end
      end
      if (i >= 9 && i <= 16) begin
        checks++;
        if (gnt_b !== 1'b1) begin failures++; $display("FAIL tie_b_burst cyc=%0d got=%b want=1", i, gnt_b); end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin req_b = 1'b0; req_a = 1'b1; end
      tick();
      checks++;
      if ({gnt_a, gnt_b, mux_sel, mux_str, busy} !== exp_vec()) begin
        failures++; $display("FAIL early_cycle%0d got=%b want=%b", i, {gnt_a, gnt_b, mux_sel, mux_str, busy}, exp_vec());
      end
    end
    checks++;
    if ({gnt_a, gnt_b, mux_str} !== 3'b100) begin
      failures++; $display("FAIL early_final got=%b want=100", {gnt_a, gnt_b, mux_str});
    end
  endtask

  task automatic test_lone_hold();
    do_reset();
    req_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({gnt_a, mux_str} !== 2'b10 || {gnt_a, gnt_b, mux_sel, mux_str, busy} !== exp_vec()) begin
        failures++; $display("FAIL lone_cycle%0d got=%b want=%b", i, {gnt_a, gnt_b, mux_sel, mux_str, busy}, exp_vec());
      end
    end
    req_a = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_b = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (gnt_b !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b want=1", gnt_b); end
    req_a = 1'b1; rst = 1'b1;
    tick();
    checks++;
    if ({gnt_a, gnt_b, mux_sel, mux_str, busy} !== 5'b00010) begin
      failures++; $display("FAIL midrst_state got=%b want=00010", {gnt_a, gnt_b, mux_sel, mux_str, busy});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({gnt_a, gnt_b, mux_sel, mux_str, busy} !== 5'b10001) begin
      failures++; $display("FAIL midrst_a_wins got=%b want=10001", {gnt_a, gnt_b, mux_sel, mux_str, busy});
    end
  endtask

`ifdef MUX158_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    lock_a = 1'b1; req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 30) req_a = 1'b0;
      tick();
      checks++;
      if ({gnt_a, gnt_b, mux_sel, mux_str, busy} !== exp_vec() || (i < 30 && gnt_a !== 1'b1)) begin
        failures++; $display("FAIL lock_cycle%0d got=%b want=%b", i, {gnt_a, gnt_b, mux_sel, mux_str, busy}, exp_vec());
      end
    end
    checks++;
    if (gnt_b !== 1'b1) begin failures++; $display("FAIL lock_handover got=%b want=1", gnt_b); end
    lock_a = 1'b0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(63) == 0);
      if ($urandom_range(3) == 0) req_a = ~req_a;
      if ($urandom_range(3) == 0) req_b = ~req_b;
`ifdef MUX158_ARB_LOCK_EN
      if ($urandom_range(7) == 0) lock_a = ~lock_a;
      if ($urandom_range(7) == 0) lock_b = ~lock_b;
`endif
      tick();
      checks++;
      if ({gnt_a, gnt_b, mux_sel, mux_str, busy} !== exp_vec()) begin
        failures++; $display("FAIL rand_cycle%0d got=%b want=%b", i, {gnt_a, gnt_b, mux_sel, mux_str, busy}, exp_vec());
      end
      checks++;
      if ((gnt_a && gnt_b) || (mux_str !== !(gnt_a ^ gnt_b))) begin
        failures++; $display("FAIL rand_invariant%0d got=%b want=onehot_or_idle", i, {gnt_a, gnt_b, mux_str});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
`ifdef MUX158_ARB_LOCK_EN
    lock_a = 1'b0; lock_b = 1'b0;
`endif
    m_owner = -1; m_guard = 0; m_sel = 0; m_lastb = 1; m_run = 0; m_pend = 0;
    test_reset();
    test_single();
    test_tie();
    test_early_release();
    test_lone_hold();
    test_reset_mid_burst();
`ifdef MUX158_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
